// File: rtl/frqdiv_prog_if.sv
// frqdiv_prog_if
//   Bundles the write port, the sync strobe and the per-channel outputs of
//   the programmable divider.
//   master : drives wr_en / wr_ch / wr_div / sync, observes the outputs
//   slave  : the divider itself
//   wr_en   1   divisor write strobe
//   wr_ch   CW  channel index for the write (indices >= CH are ignored)
//   wr_div  W   new divisor
//   sync    1   phase restart of every channel
//   sq_out  CH  per-channel square wave
//   tick    CH  per-channel one-cycle period-start pulse
//   pending CH  per-channel "written divisor waiting for the next wrap"
interface frqdiv_prog_if #(
  parameter int CH = 4,
  parameter int W  = 16,
  parameter int CW = ($clog2(CH) > 0) ? $clog2(CH) : 1
);
  logic          wr_en;
  logic [CW-1:0] wr_ch;
  logic [W-1:0]  wr_div;
  logic          sync;
  logic [CH-1:0] sq_out;
  logic [CH-1:0] tick;
  logic [CH-1:0] pending;

  modport master (
    output wr_en, wr_ch, wr_div, sync,
    input  sq_out, tick, pending
  );

  modport slave (
    input  wr_en, wr_ch, wr_div, sync,
    output sq_out, tick, pending
  );
endinterface

// File: rtl/frqdiv_prog.sv
// frqdiv_prog
//   Multi-channel run-time programmable integer clock divider. Each channel
//   divides clk by its own divisor and produces a registered square wave
//   (low half first, the extra cycle of an odd divisor goes to the low half)
//   plus a one-cycle tick at each period start. A new divisor only takes
//   effect at a period boundary, on sync, or immediately on a stopped
//   channel, so the outputs never glitch.
//   Ports:
//     clk    system clock, rising edge only
//     rst_n  asynchronous active-low reset
//     bus    frqdiv_prog_if.slave (write port, sync, sq_out/tick/pending)
module frqdiv_prog #(
  parameter int CH       = 4,
  parameter int W        = 16,
  parameter int DIV_INIT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  frqdiv_prog_if.slave  bus
);

  localparam int CW = ($clog2(CH) > 0) ? $clog2(CH) : 1;

  logic [W-1:0]  cnt_q    [CH];
  logic [W-1:0]  cnt_d    [CH];
  logic [W-1:0]  d_act_q  [CH];
  logic [W-1:0]  d_act_d  [CH];
  logic [W-1:0]  d_pend_q [CH];
  logic [W-1:0]  d_pend_d [CH];
  logic [CH-1:0] pending_q, pending_d;
  logic [CH-1:0] sq_q, sq_d;
  logic [CH-1:0] tick_q, tick_d;

  logic [CH-1:0] wr_hit;
  logic [CH-1:0] wrap;
  logic [W-1:0]  new_div  [CH];
  logic [W-1:0]  half     [CH];

  // NOTE: every always_comb output gets a default before any branch so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      // Only indices 0..CH-1 can match, so wr_ch >= CH writes nothing.
      wr_hit[i]  = bus.wr_en && (bus.wr_ch == CW'(i));
      wrap[i]    = (d_act_q[i] != '0) && (cnt_q[i] == d_act_q[i] - W'(1));
      half[i]    = d_act_q[i] - (d_act_q[i] >> 1);
      // Divisor for the period that starts at a boundary: a same-cycle
      // write beats an older pending value, which beats the current one.
      new_div[i] = wr_hit[i]    ? bus.wr_div  :
                   pending_q[i] ? d_pend_q[i] : d_act_q[i];

      cnt_d[i]     = cnt_q[i];
      d_act_d[i]   = d_act_q[i];
      d_pend_d[i]  = d_pend_q[i];
      pending_d[i] = pending_q[i];
      sq_d[i]      = 1'b0;
      tick_d[i]    = 1'b0;

      if (bus.sync) begin
        cnt_d[i]     = '0;
        d_act_d[i]   = new_div[i];
        d_pend_d[i]  = new_div[i];
        pending_d[i] = 1'b0;
      end else if (d_act_q[i] == '0) begin
        // Stopped channel: a write restarts it at once from cnt=0.
        if (wr_hit[i]) begin
          d_act_d[i]  = bus.wr_div;
          d_pend_d[i] = bus.wr_div;
        end
      end else if (wrap[i]) begin
        cnt_d[i]     = '0;
        d_act_d[i]   = new_div[i];
        d_pend_d[i]  = new_div[i];
        pending_d[i] = 1'b0;
        // A channel that stops at this boundary shows no tick.
        tick_d[i]    = (new_div[i] != '0);
      end else begin
        cnt_d[i] = cnt_q[i] + W'(1);
        sq_d[i]  = (cnt_q[i] + W'(1)) >= half[i];
        if (wr_hit[i]) begin
          d_pend_d[i]  = bus.wr_div;
          pending_d[i] = 1'b1;
        end
      end
    end
  end

  // NOTE: the per-channel arrays are a handful of flops, not a RAM, so they
  // are reset explicitly along with everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        cnt_q[i]    <= '0;
        d_act_q[i]  <= W'(DIV_INIT);
        d_pend_q[i] <= W'(DIV_INIT);
      end
      pending_q <= '0;
      sq_q      <= '0;
      tick_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      for (int i = 0; i < CH; i++) begin
        cnt_q[i]    <= cnt_d[i];
        d_act_q[i]  <= d_act_d[i];
        d_pend_q[i] <= d_pend_d[i];
      end
      pending_q <= pending_d;
      sq_q      <= sq_d;
      tick_q    <= tick_d;
    end
  end

  assign bus.sq_out  = sq_q;
  assign bus.tick    = tick_q;
  assign bus.pending = pending_q;

endmodule

// File: tb/tb_frqdiv_prog.sv
// tb_frqdiv_prog
//   Directed scenarios followed by randomized writes/syncs, checked every
//   cycle against a behavioural model of the divider. A second 3-channel
//   instance shares the stimulus: its channels must follow the model's
//   channels 0..2 while writes to index 3 leave it untouched.
module tb_frqdiv_prog;
  localparam int CH       = 4;
  localparam int W        = 16;
  localparam int DIV_INIT = 2;
  localparam int CW       = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic chk_en = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  frqdiv_prog_if #(.CH(CH), .W(W)) bus ();
  frqdiv_prog_if #(.CH(3),  .W(W)) bus3 ();

  assign bus3.wr_en  = bus.wr_en;
  assign bus3.wr_ch  = bus.wr_ch;
  assign bus3.wr_div = bus.wr_div;
  assign bus3.sync   = bus.sync;

  frqdiv_prog #(.CH(CH), .W(W), .DIV_INIT(DIV_INIT)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  frqdiv_prog #(.CH(3), .W(W), .DIV_INIT(DIV_INIT)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3.slave)
  );

  // Model: divisor in use, queued divisor, queued flag, edges elapsed in
  // the current period, and whether the last edge started a period.
  int m_d  [CH];
  int m_dp [CH];
  bit m_pd [CH];
  int m_ph [CH];
  bit m_tk [CH];

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_d[c] = DIV_INIT; m_dp[c] = DIV_INIT; m_pd[c] = 1'b0;
      m_ph[c] = 0; m_tk[c] = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (!rst_n) return;
    for (int c = 0; c < CH; c++) begin
      bit hit;
      int wd;
      hit = bus.wr_en && (int'(bus.wr_ch) == c);
      wd  = int'(bus.wr_div);
      m_tk[c] = 1'b0;
      if (bus.sync) begin
        if (hit) m_d[c] = wd; else if (m_pd[c]) m_d[c] = m_dp[c];
        m_pd[c] = 1'b0; m_ph[c] = 0;
      end else if (m_d[c] == 0) begin
        if (hit) m_d[c] = wd;
        m_ph[c] = 0;
      end else if (m_ph[c] == m_d[c] - 1) begin
        if (hit) m_d[c] = wd; else if (m_pd[c]) m_d[c] = m_dp[c];
        m_pd[c] = 1'b0; m_ph[c] = 0;
        m_tk[c] = (m_d[c] != 0);
      end else begin
        m_ph[c]++;
        if (hit) begin m_dp[c] = wd; m_pd[c] = 1'b1; end
      end
    end
  endtask

  function automatic logic [CH-1:0] exp_sq();
    logic [CH-1:0] r;
    for (int c = 0; c < CH; c++)
      r[c] = (m_d[c] != 0) && (m_ph[c] >= m_d[c] - m_d[c] / 2);
    return r;
  endfunction

  function automatic logic [CH-1:0] exp_tk();
    logic [CH-1:0] r;
    for (int c = 0; c < CH; c++) r[c] = m_tk[c];
    return r;
  endfunction

  function automatic logic [CH-1:0] exp_pd();
    logic [CH-1:0] r;
    for (int c = 0; c < CH; c++) r[c] = m_pd[c];
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  initial forever begin
    @(negedge clk);
    if (rst_n && chk_en) begin
      logic [CH-1:0] es, et, ep;
      es = exp_sq(); et = exp_tk(); ep = exp_pd();
      n_vec++;
      if (bus.sq_out !== es || bus.tick !== et || bus.pending !== ep) begin
        n_err++;
        $display("FAIL cycle4 t=%0t: sq/tick/pend got %b/%b/%b expected %b/%b/%b",
                 $time, bus.sq_out, bus.tick, bus.pending, es, et, ep);
      end
      n_vec++;
      if (bus3.sq_out !== es[2:0] || bus3.tick !== et[2:0] ||
          bus3.pending !== ep[2:0]) begin
        n_err++;
        $display("FAIL cycle3 t=%0t: sq/tick/pend got %b/%b/%b expected %b/%b/%b",
                 $time, bus3.sq_out, bus3.tick, bus3.pending,
                 es[2:0], et[2:0], ep[2:0]);
      end
    end
  end

  // One clock edge: the model sees the same inputs as the DUT, and new
  // inputs may be driven once this returns.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic wr(int c, int d);
    bus.wr_en = 1'b1; bus.wr_ch = CW'(c); bus.wr_div = W'(d);
    cycle();
    bus.wr_en = 1'b0;
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_div = '0; bus.sync = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("reset_sq",   32'(bus.sq_out),  0);
    check("reset_tick", 32'(bus.tick),    0);
    check("reset_pend", 32'(bus.pending), 0);
    chk_en = 1'b1;

    // 1: default divide-by-2 on every channel.
    cycle();
    check("t1_sq_hi",   32'(bus.sq_out), 32'hF);
    check("t1_tick_lo", 32'(bus.tick),   0);
    cycle();
    check("t1_sq_lo",   32'(bus.sq_out), 0);
    check("t1_tick_hi", 32'(bus.tick),   32'hF);

    // 2: ch1 -> 5 mid-period waits for the wrap, then 3 low / 2 high.
    wr(1, 5);
    check("t2_pend_set", 32'(bus.pending[1]), 1);
    cycle();
    check("t2_pend_clr", 32'(bus.pending[1]), 0);
    check("t2_wrap_tick", 32'(bus.tick[1]), 1);
    repeat (2) cycle();
    check("t2_sq_low",  32'(bus.sq_out[1]), 0);
    cycle();
    check("t2_sq_high", 32'(bus.sq_out[1]), 1);
    repeat (2) cycle();
    check("t2_tick_p5", 32'(bus.tick[1]), 1);

    // 3: ch2 stop, then restart with 7 while stopped.
    wr(2, 0);
    repeat (2) cycle();
    check("t3_stop_sq",   32'(bus.sq_out[2]), 0);
    check("t3_stop_tick", 32'(bus.tick[2]),   0);
    wr(2, 7);
    repeat (6) cycle();
    check("t3_no_tick_yet", 32'(bus.tick[2]), 0);
    cycle();
    check("t3_tick_7th", 32'(bus.tick[2]), 1);

    // 4: ch0 -> 4 on its wrap edge, then 6 mid-period.
    for (int k = 0; k < 4 && m_ph[0] != 1; k++) cycle();
    wr(0, 4);
    check("t4_wrap_wr_pend", 32'(bus.pending[0]), 0);
    cycle();
    wr(0, 6);
    check("t4_pend6", 32'(bus.pending[0]), 1);
    cycle();
    check("t4_no_tick_p4", 32'(bus.tick[0]), 0);
    cycle();
    check("t4_tick_p4", 32'(bus.tick[0]), 1);
    check("t4_pend_clr", 32'(bus.pending[0]), 0);
    repeat (5) cycle();
    check("t4_no_tick_p6", 32'(bus.tick[0]), 0);
    cycle();
    check("t4_tick_p6", 32'(bus.tick[0]), 1);

    // 5: sync with ch3 holding a pending divisor of 3.
    for (int k = 0; k < 4 && m_ph[3] != 0; k++) cycle();
    wr(3, 3);
    check("t5_pend3", 32'(bus.pending[3]), 1);
    bus.sync = 1'b1;
    cycle();
    bus.sync = 1'b0;
    check("t5_sync_sq",   32'(bus.sq_out),  0);
    check("t5_sync_tick", 32'(bus.tick),    0);
    check("t5_sync_pend", 32'(bus.pending), 0);
    repeat (2) cycle();
    check("t5_sq_high", 32'(bus.sq_out[3]), 1);
    cycle();
    check("t5_tick_p3", 32'(bus.tick[3]), 1);

    // 6: asynchronous reset mid-period clears everything at once.
    wr(1, 9);
    check("t6_pend_before", 32'(bus.pending[1]), 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t6_rst_sq",   32'(bus.sq_out),  0);
    check("t6_rst_tick", 32'(bus.tick),    0);
    check("t6_rst_pend", 32'(bus.pending), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Randomized writes (including index 3, absent in the 3-channel copy)
    // and occasional syncs.
    for (int n = 0; n < 3000; n++) begin
      bus.wr_en  = ($urandom_range(0, 2) == 0);
      bus.wr_ch  = CW'($urandom_range(0, 3));
      bus.wr_div = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 40))
                                                : W'($urandom_range(0, 7));
      bus.sync   = ($urandom_range(0, 49) == 0);
      cycle();
    end
    bus.wr_en = 1'b0; bus.sync = 1'b0;
    cycle();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
